// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN field lengths, CRC polynomial and TX state encoding
package can_pkg;

  localparam logic [14:0] CRC_POLY_15 = 15'h4599;
  localparam int ID_A_LEN    = 11;
  localparam int ID_B_LEN    = 18;
  localparam int DLC_LEN     = 4;
  localparam int CRC_LEN     = 15;
  localparam int DEF_EOF_LEN = 7;
  localparam int DEF_IFS_LEN = 3;

  typedef enum logic [4:0] {
    ST_IDLE, ST_SOF, ST_ID_A, ST_SRR, ST_IDE, ST_ID_B, ST_RTR, ST_R1, ST_R0,
    ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF, ST_IFS
  } tx_state_e;

  // Payload length in bits; remote frames carry none and DLC above 8 caps at 8 bytes.
  function automatic logic [6:0] data_bit_count(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 7'd0;
    if (dlc[3]) return 7'd64;
    return {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial CRC-15 register with clear and enable, shared by TX and RX
module can_crc15
  import can_pkg::*;
#(
  parameter logic [14:0] POLY = CRC_POLY_15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic [14:0] crc_q;
  logic [14:0] crc_d;
  logic        nxt;

  always_comb begin
    nxt   = bit_in ^ crc_q[14];
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[13:0], 1'b0} ^ (nxt ? POLY : 15'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_tx_serializer.sv
// rtl/can_tx_serializer.sv - CAN 2.0B TX frame serializer, SOF through intermission
// Optional CAN_TX_CRC_INJECT_EN adds crc_corrupt to invert the transmitted CRC LSB.
module can_tx_serializer
  import can_pkg::*;
#(
  parameter int          EOF_LEN  = DEF_EOF_LEN,
  parameter int          IFS_LEN  = DEF_IFS_LEN,
  parameter logic [14:0] CRC_POLY = CRC_POLY_15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [28:0] tx_id,
  input  logic        tx_ide,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
`ifdef CAN_TX_CRC_INJECT_EN
  input  logic        crc_corrupt,
`endif
  input  logic        tx_abort,
  input  logic        bit_start,
  input  logic        bit_ready,
  output logic        data_out,
  output logic        data_valid,
  output logic        stuff_en,
  output logic        tx_busy,
  output logic        tx_done
);

  tx_state_e   state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [28:0] id_q, id_d;
  logic        ide_q, ide_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [63:0] data_q, data_d;
  logic        done_q, done_d;

  logic        consume;
  logic        last;
  logic        latch;
  logic        crc_en;
  logic [6:0]  nbits;
  logic [10:0] id_a;
  logic [14:0] crc;
  logic [14:0] crc_tx;

  assign consume = bit_start && bit_ready && (state_q != ST_IDLE);
  assign last    = (cnt_q == 7'd0);
  assign latch   = (state_q == ST_IDLE) && tx_req && !tx_abort;
  assign nbits   = data_bit_count(rtr_q, dlc_q);
  assign id_a    = ide_q ? id_q[28:18] : id_q[10:0];
  assign crc_en  = consume && !tx_abort &&
                   (state_q inside {ST_SOF, ST_ID_A, ST_SRR, ST_IDE, ST_ID_B, ST_RTR,
                                    ST_R1, ST_R0, ST_DLC, ST_DATA});

`ifdef CAN_TX_CRC_INJECT_EN
  logic corrupt_q, corrupt_d;
  assign crc_tx = crc ^ {14'd0, corrupt_q};
`else
  assign crc_tx = crc;
`endif

  // The CRC register freezes after DATA, so it doubles as the shift-out snapshot.
  can_crc15 #(.POLY(CRC_POLY)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (latch),
    .en     (crc_en),
    .bit_in (data_out),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      ide_q     <= 1'b0;
      rtr_q     <= 1'b0;
      dlc_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
`ifdef CAN_TX_CRC_INJECT_EN
      corrupt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ide_q     <= ide_d;
      rtr_q     <= rtr_d;
      dlc_q     <= dlc_d;
      data_q    <= data_d;
      done_q    <= done_d;
`ifdef CAN_TX_CRC_INJECT_EN
      corrupt_q <= corrupt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    ide_d     = ide_q;
    rtr_d     = rtr_q;
    dlc_d     = dlc_q;
    data_d    = data_q;
    done_d    = 1'b0;
`ifdef CAN_TX_CRC_INJECT_EN
    corrupt_d = corrupt_q;
`endif
    if (tx_abort) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (tx_req) begin
        state_d   = ST_SOF;
        cnt_d     = '0;
        id_d      = tx_id;
        ide_d     = tx_ide;
        rtr_d     = tx_rtr;
        dlc_d     = tx_dlc;
        data_d    = tx_data;
`ifdef CAN_TX_CRC_INJECT_EN
        corrupt_d = crc_corrupt;
`endif
      end
    end else if (consume) begin
      cnt_d = cnt_q - 7'd1;
      if (state_q == ST_DATA) data_d = {data_q[62:0], 1'b0};
      if (last) begin
        cnt_d = '0;
        unique case (state_q)
          ST_SOF:     begin state_d = ST_ID_A; cnt_d = 7'(ID_A_LEN - 1); end
          ST_ID_A:    state_d = ide_q ? ST_SRR : ST_RTR;
          ST_SRR:     state_d = ST_IDE;
          ST_IDE:     begin
            state_d = ide_q ? ST_ID_B : ST_R0;
            if (ide_q) cnt_d = 7'(ID_B_LEN - 1);
          end
          ST_ID_B:    state_d = ST_RTR;
          ST_RTR:     state_d = ide_q ? ST_R1 : ST_IDE;
          ST_R1:      state_d = ST_R0;
          ST_R0:      begin state_d = ST_DLC; cnt_d = 7'(DLC_LEN - 1); end
          ST_DLC:     begin
            if (nbits == 7'd0) begin
              state_d = ST_CRC;
              cnt_d   = 7'(CRC_LEN - 1);
            end else begin
              state_d = ST_DATA;
              cnt_d   = nbits - 7'd1;
            end
          end
          ST_DATA:    begin state_d = ST_CRC; cnt_d = 7'(CRC_LEN - 1); end
          ST_CRC:     state_d = ST_CRC_DEL;
          ST_CRC_DEL: state_d = ST_ACK;
          ST_ACK:     state_d = ST_ACK_DEL;
          ST_ACK_DEL: begin state_d = ST_EOF; cnt_d = 7'(EOF_LEN - 1); end
          ST_EOF:     begin state_d = ST_IFS; cnt_d = 7'(IFS_LEN - 1); end
          ST_IFS:     begin state_d = ST_IDLE; done_d = 1'b1; end
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    data_out   = 1'b1;
    data_valid = (state_q != ST_IDLE);
    tx_busy    = (state_q != ST_IDLE);
    tx_done    = done_q;
    stuff_en   = (state_q != ST_IDLE) && (state_q <= ST_CRC);
    unique case (state_q)
      ST_SOF:  data_out = 1'b0;
      ST_ID_A: data_out = id_a[cnt_q[3:0]];
      ST_SRR:  data_out = 1'b1;
      ST_IDE:  data_out = ide_q;
      ST_ID_B: data_out = id_q[cnt_q[4:0]];
      ST_RTR:  data_out = rtr_q;
      ST_R1:   data_out = 1'b0;
      ST_R0:   data_out = 1'b0;
      ST_DLC:  data_out = dlc_q[cnt_q[1:0]];
      ST_DATA: data_out = data_q[63];
      ST_CRC:  data_out = crc_tx[cnt_q[3:0]];
      default: data_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_can_tx_serializer.sv
// tb/tb_can_tx_serializer.sv - scoreboard bench for can_tx_serializer
module tb_can_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_req = 1'b0;
  logic [28:0] tx_id = '0;
  logic        tx_ide = 1'b0;
  logic        tx_rtr = 1'b0;
  logic [3:0]  tx_dlc = '0;
  logic [63:0] tx_data = '0;
  logic        tx_abort = 1'b0;
  logic        bit_start = 1'b0;
  logic        bit_ready = 1'b1;
  logic        data_out, data_valid, stuff_en, tx_busy, tx_done;
`ifdef CAN_TX_CRC_INJECT_EN
  logic        crc_corrupt = 1'b0;
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  typedef struct packed {logic b; logic s;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  bit   mb[$];
  logic obs[$];
  int   total = 0, bad = 0;
  int   frame_bits = 0, stuffed = 0, done_cnt = 0, cyc = 0;

  can_tx_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .tx_req     (tx_req),
    .tx_id      (tx_id),
    .tx_ide     (tx_ide),
    .tx_rtr     (tx_rtr),
    .tx_dlc     (tx_dlc),
    .tx_data    (tx_data),
`ifdef CAN_TX_CRC_INJECT_EN
    .crc_corrupt(crc_corrupt),
`endif
    .tx_abort   (tx_abort),
    .bit_start  (bit_start),
    .bit_ready  (bit_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .stuff_en   (stuff_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Bit-slot strobe every third clock.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bit_start = (cyc % 3 == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Monitor: every bit about to be consumed is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && data_valid && bit_start && bit_ready && !tx_abort) begin
      obs.push_back(data_out);
      frame_bits++;
      if (stuff_en) stuffed++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_bit idx=%0d actual=%b required=none", frame_bits - 1, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({data_out, stuff_en} !== {e.b, e.s}) begin
          bad++;
          $display("FAIL frame_bit idx=%0d actual=bit%b/stuff%b required=bit%b/stuff%b",
                   frame_bits - 1, data_out, stuff_en, e.b, e.s);
        end
      end
    end
    if (tx_done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mb.push_back(v[i]);
  endtask

  // Golden frame: list the stuffed-region bits, run CRC over them, append the fixed tail.
  task automatic build_frame(input logic [28:0] id, input logic ide, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input logic corrupt);
    logic [14:0] c;
    logic        nx;
    int          nbytes;
    exp_t        e2;
    mb.delete();
    add(0, 1);
    if (ide) begin
      add(id[28:18], 11); add(1, 1); add(1, 1); add(id[17:0], 18); add(rtr, 1); add(0, 2);
    end else begin
      add(id[10:0], 11); add(rtr, 1); add(0, 2);
    end
    add(dlc, 4);
    nbytes = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
    for (int i = 0; i < nbytes; i++) add(data[63 - 8 * i -: 8], 8);
    c = '0;
    foreach (mb[i]) begin
      nx = mb[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (nx) c = c ^ 15'h4599;
    end
    if (corrupt && INJ) c[0] = ~c[0];
    add(c, 15);
    foreach (mb[i]) begin e2.b = mb[i]; e2.s = 1'b1; exp_q.push_back(e2); end
    for (int i = 0; i < 13; i++) begin e2.b = 1'b1; e2.s = 1'b0; exp_q.push_back(e2); end
  endtask

  function automatic logic [31:0] field(input int start, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], obs[start + i]};
    return v;
  endfunction

  task automatic run_frame(input logic [28:0] id, input logic ide, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data, input logic corrupt,
                           input int exp_total, input int exp_stuffed,
                           input int stall_at, input int abort_at);
    bit   stalled = 1'b0;
    bit   aborted = 1'b0;
    logic hold;
    exp_q.delete();
    build_frame(id, ide, rtr, dlc, data, corrupt);
    obs.delete();
    frame_bits = 0; stuffed = 0; done_cnt = 0;
    @(posedge clk); #2;
    tx_id = id; tx_ide = ide; tx_rtr = rtr; tx_dlc = dlc; tx_data = data;
`ifdef CAN_TX_CRC_INJECT_EN
    crc_corrupt = corrupt;
`endif
    tx_req = 1'b1;
    @(posedge clk); #2;
    chk("latch_busy", tx_busy, 1);
    chk("latch_valid", data_valid, 1);
    chk("latch_stuff", stuff_en, 1);
    chk("latch_sof", data_out, 0);
    // Inputs change and tx_req stays high while busy: neither may disturb the frame.
    tx_id = ~id; tx_ide = ~ide; tx_rtr = ~rtr; tx_dlc = ~dlc; tx_data = ~data;
    @(posedge clk); #2;
    tx_req = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0 && !aborted; i++) begin
      @(posedge clk);
      if (!stalled && frame_bits == stall_at) begin
        stalled = 1'b1;
        #2;
        bit_ready = 1'b0;
        hold = data_out;
        repeat (9) begin
          @(negedge clk);
          chk("stall_hold", data_out, hold);
        end
        @(posedge clk); #2;
        bit_ready = 1'b1;
      end
      if (!aborted && frame_bits == abort_at) begin
        #2;
        tx_abort = 1'b1;
        @(posedge clk); #2;
        tx_abort = 1'b0;
        chk("abort_dout", data_out, 1);
        chk("abort_valid", data_valid, 0);
        chk("abort_busy", tx_busy, 0);
        chk("abort_stuff", stuff_en, 0);
        aborted = 1'b1;
        exp_q.delete();
      end
    end
    if (aborted) begin
      repeat (20) @(posedge clk);
      #2;
      chk("abort_no_done", done_cnt, 0);
      chk("abort_stays_idle", tx_busy, 0);
    end else begin
      chk("done_seen", done_cnt > 0, 1);
      repeat (3) @(posedge clk);
      #2;
      chk("done_once", done_cnt, 1);
      chk("frame_total", frame_bits, exp_total);
      chk("frame_stuffed", stuffed, exp_stuffed);
      chk("sb_empty", exp_q.size(), 0);
      chk("end_busy", tx_busy, 0);
      chk("end_valid", data_valid, 0);
      chk("end_dout", data_out, 1);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_dout", data_out, 1);
    chk("rst_valid", data_valid, 0);
    chk("rst_stuff", stuff_en, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Standard frame, 1 data byte.
    run_frame(29'h123, 0, 0, 4'd1, 64'hAA00_0000_0000_0000, 0, 55, 42, -1, -1);
    chk("std_id_bits", field(1, 11), 32'h123);

    // Extended frame, no data; SRR and IDE recessive after ID_A.
    run_frame(29'h1ABCDEF0, 1, 0, 4'd0, 64'h0, 0, 67, 54, -1, -1);
    chk("ext_id_a", field(1, 11), 32'h6AF);
    chk("ext_srr_ide", field(12, 2), 32'h3);

    // Remote frame with dlc=4: DLC field sent, no payload.
    run_frame(29'h2A5, 0, 1, 4'd4, 64'hFFFF_FFFF_0000_0000, 0, 47, 34, -1, -1);
    chk("rtr_dlc", field(15, 4), 32'h4);

    // bit_ready withheld for three slots inside DATA.
    run_frame(29'h555, 0, 0, 4'd2, 64'h5A3C_0000_0000_0000, 0, 63, 50, 22, -1);

    // Abort while the CRC field is at bit 5.
    run_frame(29'h7FF, 0, 0, 4'd1, 64'h0F00_0000_0000_0000, 0, 0, 0, -1, 32);

    // Abort beats a simultaneous request in IDLE.
    @(posedge clk); #2;
    tx_req = 1'b1; tx_abort = 1'b1;
    @(posedge clk); #2;
    tx_req = 1'b0; tx_abort = 1'b0;
    chk("abort_vs_req_busy", tx_busy, 0);
    chk("abort_vs_req_valid", data_valid, 0);

    // Clean frame after abort.
    run_frame(29'h0F0, 0, 0, 4'd3, 64'h1122_3300_0000_0000, 0, 71, 58, -1, -1);

    // DLC above 8: field verbatim, payload capped; CRC LSB inverted when injection is built in.
    run_frame(29'h321, 0, 0, 4'd12, 64'h0123_4567_89AB_CDEF, 1, 111, 98, -1, -1);
    chk("dlc12_field", field(15, 4), 32'hC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_tx_serializer.md
Name: can_tx_serializer

Overview:
CAN 2.0B transmit frame serializer that sits directly upstream of the bit-stuffing stage. It latches a frame request (standard or extended ID, RTR, DLC, data) and emits it one bit per accepted bit slot, MSB first, from SOF through intermission. It computes CRC-15 on the fly and drives stuff_en so that the downstream path stuffs only SOF..CRC and bypasses stuffing for the fixed-form tail.

Parameters:
EOF_LEN, 7, number of recessive EOF bits.
IFS_LEN, 3, number of recessive intermission bits appended after EOF.
CRC_POLY, 15'h4599, CRC-15 generator polynomial (x^15 is implicit).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
tx_req  input  1  frame request, sampled in IDLE
tx_id  input  29  identifier; standard frames use tx_id[10:0]
tx_ide  input  1  1 = extended frame
tx_rtr  input  1  remote frame
tx_dlc  input  4  data length code
tx_data  input  64  payload; byte0 = tx_data[63:56]
tx_abort  input  1  abort the current frame (arbitration loss or error)
bit_start  input  1  one-clk bit-slot strobe
bit_ready  input  1  downstream can consume a bit this slot (top ties to ~stuffing_busy)
data_out  output  1  current bit
data_valid  output  1  data_out is a frame bit
stuff_en  output  1  current bit belongs to the stuffed region
tx_busy  output  1  frame in progress
tx_done  output  1  one-clk pulse when the frame completes

Behaviour:
- Reset values: data_out=1 (recessive), data_valid=0, stuff_en=0, tx_busy=0, tx_done=0, state=IDLE, CRC=0.
- Accept rule: a bit is consumed on any clk where bit_start && bit_ready && tx_busy. data_out, data_valid and stuff_en present the current bit and hold until consumed. The next bit appears on the clk after consumption.
- Request latch: in IDLE, when tx_req=1 the block registers all tx_* inputs. On the next clk: tx_busy=1, data_valid=1, stuff_en=1, data_out=0 (SOF). No bit_start is needed to latch.
- tx_req is ignored while busy.
- States and bit counts:
  - IDLE
  - SOF (1)
  - ID_A (11): standard frames send tx_id[10:0]; extended frames send tx_id[28:18].
  - Standard frame path: RTR(1), IDE=0 (1), r0=0 (1).
  - Extended frame path: SRR=1 (1), IDE=1 (1), ID_B = tx_id[17:0] (18), RTR(1), r1=0 (1), r0=0 (1).
  - DLC (4): tx_dlc sent verbatim.
  - DATA: 8*min(dlc,8) bits. Skipped if RTR=1 or dlc=0.
  - CRC (15)
  - CRC_DEL=1
  - ACK=1 (recessive)
  - ACK_DEL=1
  - EOF (EOF_LEN ones)
  - IFS (IFS_LEN ones), then back to IDLE.
- A single down-counter per state holds the remaining bits. The state advances when the counter reaches 0 on a consumed bit.
- stuff_en=1 from SOF through the last CRC bit, and 0 from CRC_DEL onward.
- CRC:
  - Cleared at latch.
  - Updated on each consumed bit from SOF through the last DATA bit: nxt = data_out ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? CRC_POLY : 0).
  - CRC shifts out MSB first from a snapshot register; it is not updated during the CRC field.
- Completion: when the last IFS bit is consumed, the block pulses tx_done for 1 clk, sets tx_busy=0, data_valid=0, data_out=1, and returns to IDLE. A new tx_req can be latched on the following clk.
- Abort: tx_abort=1 on any clk forces IDLE on the next clk with data_out=1, data_valid=0, stuff_en=0, tx_busy=0 and no tx_done. Abort has priority over consumption and over tx_req, including a simultaneous tx_req in IDLE.
- A bit_start with bit_ready=0 does not advance the frame. bit_ready is ignored when not busy.
- DLC 9..15: the DLC field is sent as given; the payload is capped at 8 bytes.

Optional Feature:
CAN_TX_CRC_INJECT_EN
- Defined: adds input crc_corrupt, sampled at request latch. When it was 1, the LSB of the transmitted CRC is inverted; used for receiver error-path testing.
- Undefined: port absent; CRC is always correct.

Decomposition:
- Package can_pkg holds:
  - CRC_POLY_15 = 15'h4599
  - ID_A_LEN = 11, ID_B_LEN = 18, DLC_LEN = 4, CRC_LEN = 15
  - default EOF_LEN and IFS_LEN
  - tx state enum
- One sub-module: can_crc15, the serial CRC-15 register with clear, enable and bit inputs, shared with the future RX checker.

Test Plan:
- Standard frame, id=0x123, dlc=1, data 0xAA, bit_ready always 1 -> 42 stuff_en=1 bits + 3 delimiter/ACK bits + 7 EOF + 3 IFS = 55 bits. ID bits read 001_0010_0011. CRC matches the golden model. tx_done pulses once.
- Extended frame, id=0x1ABCDEF0, dlc=0 -> 54 stuffed bits (SRR=1, IDE=1 at positions 13-14). No DATA field. 67 total bits.
- RTR standard frame, dlc=4 -> DLC field reads 0100, no data bits, 34 stuffed bits.
- bit_ready held 0 for 3 bit_starts in mid DATA -> data_out is stable and no bits are skipped or duplicated versus the golden sequence.
- tx_abort asserted during CRC bit 5 -> next clk data_out=1, data_valid=0, tx_busy=0, no tx_done. A following tx_req starts a clean frame with CRC cleared.
- dlc=12 with 8 data bytes -> DLC field reads 1100, exactly 64 data bits. With CAN_TX_CRC_INJECT_EN defined and crc_corrupt=1, the CRC LSB is inverted versus the model.
